// File: rtl/reloj_pkg.sv
// rtl/reloj_pkg.sv - shared BCD limits and helpers for the HH:MM:SS clock
package reloj_pkg;

    localparam int BCD_W   = 4;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    typedef logic [BCD_W-1:0] bcd_t;

    function automatic bcd_t tens_of(input int value);
        return bcd_t'(value / 10);
    endfunction

    function automatic bcd_t units_of(input int value);
        return bcd_t'(value % 10);
    endfunction

endpackage

// File: rtl/reloj_hhmmss_bcd_if.sv
// rtl/reloj_hhmmss_bcd_if.sv - control inputs and BCD digit outputs of the clock
interface reloj_hhmmss_bcd_if;
    import reloj_pkg::*;

    logic en;
    logic set_min;
    logic set_hr;
    bcd_t sec_u;
    bcd_t sec_t;
    bcd_t min_u;
    bcd_t min_t;
    bcd_t hr_u;
    bcd_t hr_t;
    logic tick_1hz;

    modport master (
        output en, set_min, set_hr,
        input  sec_u, sec_t, min_u, min_t, hr_u, hr_t, tick_1hz
    );

    modport slave (
        input  en, set_min, set_hr,
        output sec_u, sec_t, min_u, min_t, hr_u, hr_t, tick_1hz
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping to 00 at a tens/units limit
module bcd_mod_counter
    import reloj_pkg::*;
#(
    parameter bcd_t TENS_LIM  = 4'd5,
    parameter bcd_t UNITS_LIM = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output bcd_t units,
    output bcd_t tens,
    output logic carry
);

    logic at_max;

    assign at_max = (tens == TENS_LIM) && (units == UNITS_LIM);
    assign carry  = inc && at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            units <= '0;
            tens  <= '0;
        end else if (inc) begin
            if (at_max) begin
                units <= '0;
                tens  <= '0;
            end else if (units == 4'd9) begin
                units <= '0;
                tens  <= tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/reloj_hhmmss_bcd.sv
// rtl/reloj_hhmmss_bcd.sv - 24-hour BCD time-of-day counter with 1 Hz prescaler and set inputs
module reloj_hhmmss_bcd
    import reloj_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_DIV = CLK_FREQ
) (
    input  logic               clk,
    input  logic               rst,
    reloj_hhmmss_bcd_if.slave  bus
);

    localparam int             PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             pre_wrap;
    logic             tick_q;

    logic sec_carry, min_carry, hr_carry;
    logic min_inc, hr_inc;
    bcd_t sec_u, sec_t, min_u, min_t, hr_u, hr_t;

    assign pre_wrap = bus.en && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= pre_wrap;
            if (pre_wrap)
                pre_cnt <= '0;
            else if (bus.en)
                pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // A set pulse replaces the incoming carry, so a field never advances by two
    // and set_min never ripples into the hours.
    assign min_inc = sec_carry | bus.set_min;
    assign hr_inc  = (min_carry & ~bus.set_min) | bus.set_hr;

    bcd_mod_counter #(
        .TENS_LIM  (tens_of(SEC_MAX)),
        .UNITS_LIM (units_of(SEC_MAX))
    ) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (pre_wrap),
        .units (sec_u),
        .tens  (sec_t),
        .carry (sec_carry)
    );

    bcd_mod_counter #(
        .TENS_LIM  (tens_of(MIN_MAX)),
        .UNITS_LIM (units_of(MIN_MAX))
    ) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .units (min_u),
        .tens  (min_t),
        .carry (min_carry)
    );

    bcd_mod_counter #(
        .TENS_LIM  (tens_of(HR_MAX)),
        .UNITS_LIM (units_of(HR_MAX))
    ) u_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   (hr_inc),
        .units (hr_u),
        .tens  (hr_t),
        .carry (hr_carry)
    );

    assign bus.sec_u    = sec_u;
    assign bus.sec_t    = sec_t;
    assign bus.min_u    = min_u;
    assign bus.min_t    = min_t;
    assign bus.hr_u     = hr_u;
    assign bus.hr_t     = hr_t;
    assign bus.tick_1hz = tick_q;

    logic unused_hr_carry;
    assign unused_hr_carry = hr_carry;

endmodule
